// File: rtl/riscv_test_monitor_pkg.sv
// riscv_test_pkg: shared constants, status codes and FSM encoding for the test monitor
package riscv_test_pkg;

    localparam logic [31:0] HALT_INSTR = 32'hdead10cc;
    localparam logic [31:0] PASS_MAGIC = 32'h00c0ffee;
    localparam logic [31:0] FAIL_MAGIC = 32'hdeaddead;

    typedef enum logic [1:0] {
        ST_NONE    = 2'b00,
        ST_PASS    = 2'b01,
        ST_FAIL    = 2'b10,
        ST_UNKNOWN = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RSTCPU,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_e;

    function automatic status_e classify(input logic [31:0] a0);
        return a0 == PASS_MAGIC ? ST_PASS : a0 == FAIL_MAGIC ? ST_FAIL : ST_UNKNOWN;
    endfunction

endpackage

// File: rtl/riscv_test_monitor_if.sv
// riscv_test_monitor_if: probe inputs from the CPU and run/result outputs of the monitor
interface riscv_test_monitor_if;

    logic        start;
    logic [31:0] instr;
    logic [31:0] a0_val;
    logic        cpu_reset;
    logic        running;
    logic        done;
    logic [1:0]  status;
    logic        timeout;
    logic [31:0] cycle_count;

    modport master (
        output start, instr, a0_val,
        input  cpu_reset, running, done, status, timeout, cycle_count
    );

    modport slave (
        input  start, instr, a0_val,
        output cpu_reset, running, done, status, timeout, cycle_count
    );

endinterface

// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: resets the CPU, counts run cycles, detects halt/timeout and grades a0
module riscv_test_monitor
    import riscv_test_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = 10000,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    riscv_test_monitor_if.slave  mon
);

    state_e      state_q, state_d;
    logic [31:0] rcnt_q, rcnt_d;
    logic [31:0] cnt_q, cnt_d;
    status_e     status_q, status_d;
    logic        timeout_q, timeout_d;

    // next-state: run sequencing, cycle counting and result classification
    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        cnt_d     = cnt_q;
        status_d  = status_q;
        timeout_d = timeout_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (mon.start) begin
                    state_d = S_RSTCPU;
                    rcnt_d  = 32'(RST_CYCLES - 1);
                end
            end
            S_RSTCPU: begin
                if (rcnt_q == '0) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    status_d  = ST_NONE;
                    timeout_d = 1'b0;
                end else begin
                    rcnt_d = rcnt_q - 32'd1;
                end
            end
            S_RUN: begin
                if (mon.instr == HALT_INSTR) begin
                    state_d = S_CHECK;
                end else if (cnt_q == 32'(MAX_CYCLES)) begin
                    state_d   = S_CHECK;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_CHECK: begin
                status_d = timeout_q ? ST_UNKNOWN : classify(mon.a0_val);
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rcnt_q    <= '0;
            cnt_q     <= '0;
            status_q  <= ST_NONE;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            cnt_q     <= cnt_d;
            status_q  <= status_d;
            timeout_q <= timeout_d;
        end
    end

    // CPU is released only while running or grading; everything decodes from registers
    assign mon.cpu_reset   = !(state_q inside {S_RUN, S_CHECK});
    assign mon.running     = state_q == S_RUN;
    assign mon.done        = state_q == S_DONE;
    assign mon.status      = status_q;
    assign mon.timeout     = timeout_q;
    assign mon.cycle_count = cnt_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb_riscv_test_monitor: directed checks of run control, halt/timeout detection and grading
module tb_riscv_test_monitor;
    import riscv_test_pkg::*;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [31:0] instr = NOP;
    logic [31:0] a0 = '0;
    logic        sel = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    riscv_test_monitor_if ifa ();
    riscv_test_monitor_if ifb ();

    assign ifa.start  = start_a;
    assign ifa.instr  = instr;
    assign ifa.a0_val = a0;
    assign ifb.start  = start_b;
    assign ifb.instr  = instr;
    assign ifb.a0_val = a0;

    riscv_test_monitor #(.MAX_CYCLES(10000), .RST_CYCLES(2)) dut_a (
        .clock (clock),
        .reset (reset),
        .mon   (ifa)
    );

    riscv_test_monitor #(.MAX_CYCLES(16), .RST_CYCLES(2)) dut_b (
        .clock (clock),
        .reset (reset),
        .mon   (ifb)
    );

    logic        m_cpu_reset, m_running, m_done, m_timeout;
    logic [1:0]  m_status;
    logic [31:0] m_cnt;

    assign m_cpu_reset = sel ? ifb.cpu_reset   : ifa.cpu_reset;
    assign m_running   = sel ? ifb.running     : ifa.running;
    assign m_done      = sel ? ifb.done        : ifa.done;
    assign m_timeout   = sel ? ifb.timeout     : ifa.timeout;
    assign m_status    = sel ? ifb.status      : ifa.status;
    assign m_cnt       = sel ? ifb.cycle_count : ifa.cycle_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start_b = v;
        else start_a = v;
    endtask

    task automatic launch(input string tag);
        int k;
        set_start(1'b1);
        @(negedge clock);
        set_start(1'b0);
        check({tag, "_rst_held"}, 32'(m_cpu_reset), 32'd1);
        k = 1;
        while (!m_running && k < 10) begin
            @(negedge clock);
            k++;
        end
        check({tag, "_latency"}, 32'(k), 32'd3);
        check({tag, "_released"}, 32'(m_cpu_reset), 32'd0);
    endtask

    task automatic run(input string tag, input int n, input logic [31:0] v, input int poke,
                       input logic halt, input logic [1:0] exp_st, input logic [31:0] exp_cnt,
                       input logic exp_to);
        launch(tag);
        a0 = v;
        for (int i = 0; i < n; i++) begin
            set_start(i == poke);
            @(negedge clock);
            set_start(1'b0);
        end
        if (halt) instr = HALT_INSTR;
        @(negedge clock);
        instr = NOP;
        check({tag, "_chk_done"}, 32'(m_done), 32'd0);
        check({tag, "_chk_run"}, 32'(m_running), 32'd0);
        @(negedge clock);
        check({tag, "_done"}, 32'(m_done), 32'd1);
        check({tag, "_cpu_rst"}, 32'(m_cpu_reset), 32'd1);
        check({tag, "_status"}, 32'(m_status), 32'(exp_st));
        check({tag, "_count"}, m_cnt, exp_cnt);
        check({tag, "_timeout"}, 32'(m_timeout), 32'(exp_to));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clock);
        check("rst_cpu_reset", 32'(ifa.cpu_reset), 32'd1);
        check("rst_running", 32'(ifa.running), 32'd0);
        check("rst_done", 32'(ifa.done), 32'd0);
        check("rst_status", 32'(ifa.status), 32'd0);
        check("rst_timeout", 32'(ifa.timeout), 32'd0);
        check("rst_count", ifa.cycle_count, 32'd0);
        check("rst_b_cpu_reset", 32'(ifb.cpu_reset), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("idle_cpu_reset", 32'(ifa.cpu_reset), 32'd1);
        check("idle_running", 32'(ifa.running), 32'd0);
        sel = 1'b0;
        run("pass", 37, PASS_MAGIC, -1, 1'b1, ST_PASS, 32'd37, 1'b0);
        run("fail", 10, FAIL_MAGIC, -1, 1'b1, ST_FAIL, 32'd10, 1'b0);
        run("unk", 5, 32'd5, -1, 1'b1, ST_UNKNOWN, 32'd5, 1'b0);
        run("ignore", 12, PASS_MAGIC, 5, 1'b1, ST_PASS, 32'd12, 1'b0);
        sel = 1'b1;
        run("tmo", 16, PASS_MAGIC, -1, 1'b0, ST_UNKNOWN, 32'd16, 1'b1);
        run("coin", 16, PASS_MAGIC, -1, 1'b1, ST_PASS, 32'd16, 1'b0);
        run("coinf", 16, FAIL_MAGIC, -1, 1'b1, ST_FAIL, 32'd16, 1'b0);
        sel = 1'b0;
        launch("abort");
        repeat (7) @(negedge clock);
        check("abort_pre_running", 32'(m_running), 32'd1);
        check("abort_pre_count", m_cnt, 32'd7);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("abort_running", 32'(m_running), 32'd0);
        check("abort_cpu_reset", 32'(m_cpu_reset), 32'd1);
        check("abort_count", m_cnt, 32'd0);
        check("abort_done", 32'(m_done), 32'd0);
        check("abort_status", 32'(m_status), 32'd0);
        check("abort_timeout", 32'(m_timeout), 32'd0);
        @(negedge clock);
        check("abort_stays_idle", 32'(m_running), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
